// File: rtl/adaptive_clock_recovery_if.sv
// Bundle of the edge-strobe inputs and recovered-clock outputs of
// adaptive_clock_recovery. The master side is the upstream edge detector
// and downstream decoder; the slave side is the recovery block itself.
interface adaptive_clock_recovery_if #(
    parameter int CNT_WIDTH = 8
);
    logic                 pos_edge;
    logic                 neg_edge;
    logic                 manchester_clock;
    logic                 toggle_strobe;
    logic [CNT_WIDTH-1:0] period_out;
    logic                 locked;
    logic                 edge_error;

    modport master (
        output pos_edge,
        output neg_edge,
        input  manchester_clock,
        input  toggle_strobe,
        input  period_out,
        input  locked,
        input  edge_error
    );

    modport slave (
        input  pos_edge,
        input  neg_edge,
        output manchester_clock,
        output toggle_strobe,
        output period_out,
        output locked,
        output edge_error
    );
endinterface

// File: rtl/adaptive_clock_recovery.sv
// Adaptive Manchester clock recovery.
// Regenerates the half-bit clock from line edge strobes, rejects glitch
// edges, coasts through missing edges with a timeout, and tracks lock.
// Optional macro ADAPTIVE_PERIOD_EN: when defined, in-window edges nudge the
// period estimate one cycle toward the measured interval; when undefined the
// period stays at INIT_PERIOD.
module adaptive_clock_recovery #(
    parameter int CNT_WIDTH   = 8,
    parameter int INIT_PERIOD = 10,
    parameter int MIN_PERIOD  = 3,
    parameter int TOL         = 2,
    parameter int LOCK_COUNT  = 4,
    parameter int MAX_COAST   = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    adaptive_clock_recovery_if.slave    bus
);

    localparam int RUN_W   = $clog2(LOCK_COUNT + 1);
    localparam int COAST_W = $clog2(MAX_COAST + 1);

    localparam logic [CNT_WIDTH-1:0] INIT_P = CNT_WIDTH'(INIT_PERIOD);
    localparam logic [CNT_WIDTH-1:0] MIN_P  = CNT_WIDTH'(MIN_PERIOD);
    localparam logic [CNT_WIDTH-1:0] TOL_C  = CNT_WIDTH'(TOL);
    // Upper clamp keeps period + TOL representable so the counter never wraps.
    localparam logic [CNT_WIDTH-1:0] MAX_P  = CNT_WIDTH'((2 ** CNT_WIDTH) - 1 - TOL);

    localparam logic [RUN_W-1:0]   LOCK_C  = RUN_W'(LOCK_COUNT);
    localparam logic [COAST_W-1:0] COAST_C = COAST_W'(MAX_COAST);

    localparam logic signed [CNT_WIDTH+1:0] STEP_UP = (CNT_WIDTH + 2)'(1);
    localparam logic signed [CNT_WIDTH+1:0] STEP_DN = (CNT_WIDTH + 2)'(-1);

    // What happens in the current cycle, in priority order.
    typedef enum logic [1:0] {
        EV_IDLE,
        EV_GLITCH,
        EV_ACCEPT,
        EV_TIMEOUT
    } event_t;

    event_t ev;

    logic [CNT_WIDTH-1:0] counter,  counter_nxt;
    logic [CNT_WIDTH-1:0] period,   period_nxt;
    logic                 mclk,     mclk_nxt;
    logic                 strobe,   strobe_nxt;
    logic                 locked,   locked_nxt;
    logic                 err,      err_nxt;
    logic [RUN_W-1:0]     lock_run, lock_run_nxt;
    logic [COAST_W-1:0]   coast_run, coast_run_nxt;
    logic                 ref_valid, ref_valid_nxt;

    logic                        edge_seen;
    logic signed [CNT_WIDTH:0]   diff;
    logic signed [CNT_WIDTH:0]   mag;
    logic                        in_window;
    logic signed [CNT_WIDTH+1:0] step;

    // Saturating increment of the in-window run length.
    function automatic logic [RUN_W-1:0] sat_run(input logic [RUN_W-1:0] v);
        return (v >= LOCK_C) ? LOCK_C : v + 1'b1;
    endfunction

    // Saturating increment of the consecutive-timeout count.
    function automatic logic [COAST_W-1:0] sat_coast(input logic [COAST_W-1:0] v);
        return (v >= COAST_C) ? COAST_C : v + 1'b1;
    endfunction

    // Clamp a candidate period into [MIN_P, MAX_P].
    function automatic logic [CNT_WIDTH-1:0] clamp_period(input logic signed [CNT_WIDTH+1:0] p);
        if (p < $signed({2'b00, MIN_P})) begin
            return MIN_P;
        end else if (p > $signed({2'b00, MAX_P})) begin
            return MAX_P;
        end else begin
            return p[CNT_WIDTH-1:0];
        end
    endfunction

    // Classify the cycle and measure the interval against the period.
    always_comb begin
        edge_seen = bus.pos_edge | bus.neg_edge;
        diff      = $signed({1'b0, counter}) - $signed({1'b0, period});
        mag       = diff[CNT_WIDTH] ? -diff : diff;
        in_window = ref_valid && (mag <= $signed({1'b0, TOL_C}));

        if (edge_seen && (counter < MIN_P)) begin
            ev = EV_GLITCH;
        end else if (edge_seen) begin
            ev = EV_ACCEPT;
        end else if (counter == (period + TOL_C)) begin
            ev = EV_TIMEOUT;
        end else begin
            ev = EV_IDLE;
        end
    end

    // Next-state values for the tracking state and registered outputs.
    always_comb begin
        counter_nxt   = counter + 1'b1;
        mclk_nxt      = mclk;
        strobe_nxt    = 1'b0;
        err_nxt       = 1'b0;
        locked_nxt    = locked;
        lock_run_nxt  = lock_run;
        coast_run_nxt = coast_run;
        ref_valid_nxt = ref_valid;
        step          = '0;

        case (ev)
            EV_GLITCH: begin
                err_nxt      = 1'b1;
                lock_run_nxt = '0;
                locked_nxt   = 1'b0;
            end
            EV_ACCEPT: begin
                mclk_nxt      = ~mclk;
                strobe_nxt    = 1'b1;
                counter_nxt   = '0;
                coast_run_nxt = '0;
                ref_valid_nxt = 1'b1;
                if (in_window) begin
                    lock_run_nxt = sat_run(lock_run);
                    locked_nxt   = (lock_run_nxt == LOCK_C);
`ifdef ADAPTIVE_PERIOD_EN
                    if (diff[CNT_WIDTH]) begin
                        step = STEP_DN;
                    end else if (diff != '0) begin
                        step = STEP_UP;
                    end
`endif
                end else begin
                    lock_run_nxt = '0;
                    locked_nxt   = 1'b0;
                end
            end
            EV_TIMEOUT: begin
                mclk_nxt      = ~mclk;
                strobe_nxt    = 1'b1;
                counter_nxt   = '0;
                ref_valid_nxt = 1'b0;
                coast_run_nxt = sat_coast(coast_run);
                if (coast_run_nxt == COAST_C) begin
                    locked_nxt   = 1'b0;
                    lock_run_nxt = '0;
                end
            end
            default: ;
        endcase

        period_nxt = clamp_period($signed({2'b00, period}) + step);
    end

    // State register with synchronous reset taking priority over every event.
    always_ff @(posedge clock) begin
        if (reset) begin
            counter   <= '0;
            period    <= INIT_P;
            mclk      <= 1'b0;
            strobe    <= 1'b0;
            locked    <= 1'b0;
            err       <= 1'b0;
            lock_run  <= '0;
            coast_run <= '0;
            ref_valid <= 1'b0;
        end else begin
            counter   <= counter_nxt;
            period    <= period_nxt;
            mclk      <= mclk_nxt;
            strobe    <= strobe_nxt;
            locked    <= locked_nxt;
            err       <= err_nxt;
            lock_run  <= lock_run_nxt;
            coast_run <= coast_run_nxt;
            ref_valid <= ref_valid_nxt;
        end
    end

    assign bus.manchester_clock = mclk;
    assign bus.toggle_strobe    = strobe;
    assign bus.period_out       = period;
    assign bus.locked           = locked;
    assign bus.edge_error       = err;

endmodule
